pmem_loader: RTL

Program-memory loader: the write-side counterpart of the program memory read port. It accepts a 16-bit halfword stream from the host link, parses a small header (start address, word count), assembles low/high halfword pairs into 32-bit instruction words, and issues one registered write per word into program memory. While a load is in progress it holds the core, so instruction fetch never observes a half-written image.

---
 rtl/pmem_pkg.sv | 22 ++
 rtl/pmem_loader.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pmem_pkg.sv
// pmem_pkg: shared types and constants for the program-memory loader.
//   pmem_ld_state_t : loader FSM state encoding
//   PMEM_ADDR_W     : program-memory word-index width (32768 words)
//   PMEM_HW_W       : stream halfword width
package pmem_pkg;

    localparam int PMEM_ADDR_W = 15;
    localparam int PMEM_HW_W   = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_L,
        ST_ADDR_H,
        ST_CNT_L,
        ST_CNT_H,
        ST_DATA_L,
        ST_DATA_H,
        ST_CSUM,
        ST_DONE
    } pmem_ld_state_t;

endpackage

// File: rtl/pmem_loader.sv
// pmem_loader: turns a 16-bit host halfword stream into program-memory writes.
// Stream layout: addr_lo, addr_hi, cnt_lo, cnt_hi, then cnt x (data_lo, data_hi),
// then one checksum halfword when LOADER_CHECKSUM_EN is defined.
// The core is held for the whole load so fetch never sees a half-written image.
//
// Optional feature macro: LOADER_CHECKSUM_EN (16-bit payload sum check).
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start_c0            : pulse that begins a load (IDLE only)
//   in_valid_c0/data_c0 : halfword stream input
//   in_ready_c0         : halfword accepted this cycle when valid
//   pmem_we_c1/waddr_c1/wdata_c1 : registered program-memory write port
//   cpu_hold            : high from the cycle after start through DONE
//   done_c1             : one-cycle end-of-load pulse
//   error_c1            : sticky checksum mismatch (0 without the macro)
module pmem_loader
    import pmem_pkg::*;
#(
    parameter int ADDR_W = PMEM_ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_c0,
    input  logic                 in_valid_c0,
    input  logic [PMEM_HW_W-1:0] in_data_c0,
    output logic                 in_ready_c0,
    output logic                 pmem_we_c1,
    output logic [ADDR_W-1:0]    pmem_waddr_c1,
    output logic [31:0]          pmem_wdata_c1,
    output logic                 cpu_hold,
    output logic                 done_c1,
    output logic                 error_c1
);

`ifdef LOADER_CHECKSUM_EN
    localparam pmem_ld_state_t END_ST = ST_CSUM;
`else
    localparam pmem_ld_state_t END_ST = ST_DONE;
`endif

    pmem_ld_state_t       state_q, state_d;
    logic [PMEM_HW_W-1:0] lo_q;      // low halfword of the field being assembled
    logic [ADDR_W-1:0]    widx_q;    // next word index to write
    logic [31:0]          cnt_q;     // words still to write
    logic                 we_q;
    logic [ADDR_W-1:0]    waddr_q;
    logic [31:0]          wdata_q;
    logic                 hs;
    logic [31:0]          word_in;   // current halfword paired with the latched low half

    assign hs      = in_valid_c0 && in_ready_c0;
    assign word_in = {in_data_c0, lo_q};

    // state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_c0) state_d = ST_ADDR_L;
            ST_ADDR_L: if (hs) state_d = ST_ADDR_H;
            ST_ADDR_H: if (hs) state_d = ST_CNT_L;
            ST_CNT_L:  if (hs) state_d = ST_CNT_H;
            ST_CNT_H:  if (hs) state_d = (word_in != 32'd0) ? ST_DATA_L : END_ST;
            ST_DATA_L: if (hs) state_d = ST_DATA_H;
            // cnt_q still holds the pre-decrement count here
            ST_DATA_H: if (hs) state_d = (cnt_q == 32'd1) ? END_ST : ST_DATA_L;
            ST_CSUM:   if (hs) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        in_ready_c0 = (state_q != ST_IDLE) && (state_q != ST_DONE);
        cpu_hold    = (state_q != ST_IDLE);
        done_c1     = (state_q == ST_DONE);
    end

    // datapath: header capture, word assembly, registered write
    always_ff @(posedge clk) begin
        if (reset) begin
            lo_q    <= '0;
            widx_q  <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= 1'b0;
            if (hs) begin
                case (state_q)
                    ST_ADDR_L, ST_CNT_L, ST_DATA_L: lo_q <= in_data_c0;
                    ST_ADDR_H: widx_q <= word_in[ADDR_W+1:2];  // byte addr -> word index
                    ST_CNT_H:  cnt_q  <= word_in;
                    ST_DATA_H: begin
                        we_q    <= 1'b1;
                        waddr_q <= widx_q;
                        wdata_q <= word_in;
                        widx_q  <= widx_q + {{(ADDR_W-1){1'b0}}, 1'b1};  // wraps mod 2^ADDR_W
                        cnt_q   <= cnt_q - 32'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign pmem_we_c1    = we_q;
    assign pmem_waddr_c1 = waddr_q;
    assign pmem_wdata_c1 = wdata_q;

`ifdef LOADER_CHECKSUM_EN
    logic [PMEM_HW_W-1:0] sum_q;
    logic                 err_q;

    // payload-only running sum; cleared together with the error flag on start
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else if (state_q == ST_IDLE && start_c0) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else if (hs) begin
            if (state_q == ST_DATA_L || state_q == ST_DATA_H)
                sum_q <= sum_q + in_data_c0;
            else if (state_q == ST_CSUM && in_data_c0 != sum_q)
                err_q <= 1'b1;
        end
    end

    assign error_c1 = err_q;
`else
    assign error_c1 = 1'b0;
`endif

endmodule
